// File: rtl/demux64_1_4.sv
// demux64_1_4 -- registered 1-to-4 demultiplexer for WIDTH-bit words.
//
// The block accepts one input word per cycle and writes it into the
// one-entry holding register of the channel named by in_sel. Each channel
// has its own valid/ready handshake towards its consumer. Each channel also
// has a wrapping counter of the words accepted into it.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        input word present
//   in_ready   out  1        input accepted this cycle (selected channel free)
//   in_sel     in   2        destination channel 0..3
//   in_data    in   WIDTH    input word
//   out_valid  out  4        bit k: channel k holds a word
//   out_ready  in   4        bit k: channel k consumer takes the word
//   out_data0..out_data3  out  WIDTH   channel holding registers
//   xfer_cnt0..xfer_cnt3  out  CNT_W   words accepted per channel, wrapping
module demux64_1_4 #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] xfer_cnt0,
    output logic [CNT_W-1:0] xfer_cnt1,
    output logic [CNT_W-1:0] xfer_cnt2,
    output logic [CNT_W-1:0] xfer_cnt3
);

    logic [3:0]       valid_q;
    logic [WIDTH-1:0] data_q [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic             accept;
    logic [3:0]       load;

    // Readiness looks only at the selected channel. A stalled channel
    // therefore never blocks words headed elsewhere. A full channel whose
    // consumer is taking its word this cycle can be refilled on the same edge.
    always_comb begin
        in_ready = ~valid_q[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
        load     = '0;
        if (accept) begin
            load[in_sel] = 1'b1;
        end
    end

    // Data is never cleared on drain, only overwritten by a new accept.
    // A load takes priority over a drain, so valid stays set across a
    // same-cycle replace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k]  <= in_data;
                    valid_q[k] <= 1'b1;
                    cnt_q[k]   <= cnt_q[k] + CNT_W'(1);
                end else if (valid_q[k] && out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_valid = valid_q;
        out_data0 = data_q[0];
        out_data1 = data_q[1];
        out_data2 = data_q[2];
        out_data3 = data_q[3];
        xfer_cnt0 = cnt_q[0];
        xfer_cnt1 = cnt_q[1];
        xfer_cnt2 = cnt_q[2];
        xfer_cnt3 = cnt_q[3];
    end

endmodule
